// File: rtl/bnn_pe_array_param.sv
// Binary XNOR-popcount PE array: loads O_CH x ROW_LENGTH weights and ROW_LENGTH activations, streams per-channel psums.
// Optional BNN_SIGN_OUT_EN builds the sign comparator on out_sign; otherwise out_sign is tied low.
//
// state    | meaning
// S_LOAD_W | accepting weight words, row-major by channel
// S_LOAD_A | accepting activation words
// S_OUT    | presenting channel results, advancing on out handshake
module bnn_pe_array_param #(
  parameter int DATA_W     = 27,
  parameter int ROW_LENGTH = 7,
  parameter int O_CH       = 9,
  parameter int PSUM_W     = $clog2(DATA_W*ROW_LENGTH+1),
  localparam int CH_W      = (O_CH > 1) ? $clog2(O_CH) : 1,
  localparam int COL_W     = (ROW_LENGTH > 1) ? $clog2(ROW_LENGTH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              keep_weights,
  output logic [PSUM_W-1:0] out_psum,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_sign,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);

  typedef enum logic [1:0] {S_LOAD_W, S_LOAD_A, S_OUT} state_t;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(O_CH-1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LENGTH-1);

  state_t            state;
  logic [CH_W-1:0]   wrow;
  logic [COL_W-1:0]  wcol;
  logic [COL_W-1:0]  acnt;
  logic [CH_W-1:0]   ch;
  logic [DATA_W-1:0] weight [O_CH][ROW_LENGTH];
  logic [DATA_W-1:0] act    [ROW_LENGTH];
  logic [PSUM_W-1:0] psum_c;
  logic [CH_W-1:0]   ch_next;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign ch_next  = ch + 1'b1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_LOAD_W;
      wrow      <= '0;
      wcol      <= '0;
      acnt      <= '0;
      ch        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int c = 0; c < O_CH; c++)
        for (int k = 0; k < ROW_LENGTH; k++)
          weight[c][k] <= '0;
      for (int k = 0; k < ROW_LENGTH; k++)
        act[k] <= '0;
    end else begin
      case (state)
        S_LOAD_W: begin
          if (in_fire) begin
            weight[wrow][wcol] <= in_data;
            if (wcol == COL_LAST) begin
              wcol <= '0;
              if (wrow == CH_LAST) begin
                wrow  <= '0;
                state <= S_LOAD_A;
              end else begin
                wrow <= wrow + 1'b1;
              end
            end else begin
              wcol <= wcol + 1'b1;
            end
          end
        end
        S_LOAD_A: begin
          if (in_fire) begin
            act[acnt] <= in_data;
            if (acnt == COL_LAST) begin
              acnt      <= '0;
              ch        <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_last  <= (O_CH == 1);
              state     <= S_OUT;
            end else begin
              acnt <= acnt + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (out_fire) begin
            if (ch == CH_LAST) begin
              ch        <= '0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= keep_weights ? S_LOAD_A : S_LOAD_W;
            end else begin
              ch       <= ch_next;
              out_last <= (ch_next == CH_LAST);
            end
          end
        end
        default: begin
          state     <= S_LOAD_W;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    psum_c = '0;
    for (int k = 0; k < ROW_LENGTH; k++)
      psum_c = psum_c + PSUM_W'($countones(~(weight[ch][k] ^ act[k])));
  end

  // Gated so idle/reset outputs read 0 rather than the psum of the cleared registers.
  assign out_psum = out_valid ? psum_c : '0;
  assign out_ch   = ch;

`ifdef BNN_SIGN_OUT_EN
  localparam logic [PSUM_W:0] SUM_MAX = (PSUM_W+1)'(DATA_W*ROW_LENGTH);
  assign out_sign = ({out_psum, 1'b0} >= SUM_MAX);
`else
  assign out_sign = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_pe_array_param.sv
// Directed table-driven bench for bnn_pe_array_param at default parameters.
module tb_bnn_pe_array_param;
  localparam int DATA_W = 27;
  localparam int ROW_LENGTH = 7;
  localparam int O_CH = 9;
  localparam int PSUM_W = 8;
  localparam int CH_W = 4;
  localparam logic [DATA_W-1:0] ONES = '1;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              keep_weights;
  logic [PSUM_W-1:0] out_psum;
  logic [CH_W-1:0]   out_ch;
  logic              out_sign;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  bnn_pe_array_param dut (
    .clk_in(clk_in), .rst_in(rst_in), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .keep_weights(keep_weights), .out_psum(out_psum),
    .out_ch(out_ch), .out_sign(out_sign), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic                         load_w;
    logic [1:0]                   wmode;   // 0 all ones, 1 staircase, 2 all zero
    logic [DATA_W-1:0]            act;
    logic                         keep;
    logic [3:0]                   stall;   // channel to hold out_ready low at; 15 = none
    logic [O_CH-1:0][PSUM_W-1:0]  exp;
  } vec_t;

  vec_t vecs [5];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] wword(input logic [1:0] mode, input int c, input int k);
    case (mode)
      2'd0:    return ONES;
      2'd1:    return (k < c) ? ONES : '0;
      default: return '0;
    endcase
  endfunction

  function automatic logic exp_sign(input logic [PSUM_W-1:0] p);
`ifdef BNN_SIGN_OUT_EN
    return (2 * int'(p) >= DATA_W * ROW_LENGTH);
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic send_word(input logic [DATA_W-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL send_word_timeout actual=in_ready_low expected=in_ready_high");
    end
    @(negedge clk_in);
    in_valid = 1'b0;
  endtask

  task automatic load_frame(input vec_t v, input int idx);
    if (v.load_w)
      for (int c = 0; c < O_CH; c++)
        for (int k = 0; k < ROW_LENGTH; k++)
          send_word(wword(v.wmode, c, k));
    for (int k = 0; k < ROW_LENGTH-1; k++)
      send_word(v.act);
    check($sformatf("v%0d_early_valid", idx), 32'(out_valid), 32'd0);
    send_word(v.act);
    check($sformatf("v%0d_first_valid", idx), 32'(out_valid), 32'd1);
  endtask

  task automatic drain_frame(input vec_t v, input int idx);
    // A pending input word during OUT must not be consumed.
    in_valid = 1'b1;
    in_data  = ONES;
    for (int c = 0; c < O_CH; c++) begin
      if (c == int'(v.stall)) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk_in);
          check($sformatf("v%0d_stall%0d_ch", idx, s), 32'(out_ch), 32'(c));
          check($sformatf("v%0d_stall%0d_psum", idx, s), 32'(out_psum), 32'(v.exp[c]));
          check($sformatf("v%0d_stall%0d_valid", idx, s), 32'(out_valid), 32'd1);
        end
      end
      check($sformatf("v%0d_c%0d_valid", idx, c), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_c%0d_ch", idx, c), 32'(out_ch), 32'(c));
      check($sformatf("v%0d_c%0d_psum", idx, c), 32'(out_psum), 32'(v.exp[c]));
      check($sformatf("v%0d_c%0d_sign", idx, c), 32'(out_sign), 32'(exp_sign(v.exp[c])));
      check($sformatf("v%0d_c%0d_last", idx, c), 32'(out_last), 32'(c == O_CH-1));
      check($sformatf("v%0d_c%0d_in_ready", idx, c), 32'(in_ready), 32'd0);
      keep_weights = (c == O_CH-1) ? v.keep : ~v.keep;
      out_ready = 1'b1;
      @(negedge clk_in);
      out_ready = 1'b0;
    end
    in_valid = 1'b0;
    keep_weights = 1'b0;
    check($sformatf("v%0d_done_valid", idx), 32'(out_valid), 32'd0);
    check($sformatf("v%0d_done_in_ready", idx), 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_out_psum"}, 32'(out_psum), 32'd0);
    check({tag, "_out_ch"}, 32'(out_ch), 32'd0);
    check({tag, "_out_sign"}, 32'(out_sign), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd0, ONES, 1'b0, 4'd15, {9{8'd189}}};
    vecs[1] = '{1'b1, 2'd0, '0,   1'b0, 4'd15, {9{8'd0}}};
    vecs[2] = '{1'b1, 2'd1, ONES, 1'b1, 4'd15,
                {8'd189, 8'd189, 8'd162, 8'd135, 8'd108, 8'd81, 8'd54, 8'd27, 8'd0}};
    vecs[3] = '{1'b0, 2'd1, '0,   1'b0, 4'd15,
                {8'd0, 8'd0, 8'd27, 8'd54, 8'd81, 8'd108, 8'd135, 8'd162, 8'd189}};
    vecs[4] = '{1'b1, 2'd1, ONES, 1'b0, 4'd2,
                {8'd189, 8'd189, 8'd162, 8'd135, 8'd108, 8'd81, 8'd54, 8'd27, 8'd0}};

    rst_in = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    keep_weights = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk_in);
    check_reset_values("por");
    rst_in = 1'b0;
    @(negedge clk_in);

    for (int i = 0; i < 5; i++) begin
      load_frame(vecs[i], i);
      drain_frame(vecs[i], i);
    end

    // Abort a weight load part-way; the next frame must need the full word count.
    for (int k = 0; k < 30; k++)
      send_word(ONES);
    rst_in = 1'b1;
    @(negedge clk_in);
    check_reset_values("midload_rst");
    rst_in = 1'b0;
    load_frame(vecs[0], 5);
    drain_frame(vecs[0], 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end
endmodule
